phase_run_controller: RTL and testbench

//   Parametrised run/phase sequencer for the multicycle core. Owns the one-hot

---
 rtl/phase_run_controller.sv | 123 ++++++++++++
 tb/tb_phase_run_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_run_controller.sv
`timescale 1ns/1ps
// Run/phase sequencer for the multicycle core: one-hot phase, pc, flags,
// branch resolution and run/stop/step/halt control with memory wait states.
module phase_run_controller #(
  parameter int unsigned AW       = 16,
  parameter int unsigned NPHASE   = 4,
  parameter int unsigned CW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic              step,
  input  logic              mem_ready,
  input  logic              halt_req,
  input  logic              flag_we,
  input  logic [3:0]        flags_in,
  input  logic              br_en,
  input  logic [2:0]        br_cond,
  input  logic [AW-1:0]     br_target,
  output logic [NPHASE-1:0] phase,
  output logic [AW-1:0]     pc,
  output logic [3:0]        flags,
  output logic              running,
  output logic              halted,
  output logic [CW-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [NPHASE-1:0]   phase_n;
  logic [AW-1:0]       pc_n;
  logic [3:0]          flags_n;
  logic [CW-1:0]       retired_n;
  logic                active;
  logic                retire;
  logic                cond_ok;
  logic                taken;

  assign active = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
  assign retire = active && mem_ready && phase[NPHASE-1];

  // Branch condition on the flags held before this retire's update ({S,Z,C,V}).
  always_comb begin
    cond_ok = 1'b0;
    case (br_cond)
      3'b000:  cond_ok = flags[2];
      3'b001:  cond_ok = flags[3] ^ flags[0];
      3'b010:  cond_ok = flags[2] | (flags[3] ^ flags[0]);
      3'b011:  cond_ok = ~flags[2];
      3'b100:  cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign taken = br_en && cond_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    pc_n      = pc;
    flags_n   = flags;
    retired_n = retired;

    case (state)
      S_IDLE: begin
        if (exec)      state_n = S_RUN;
        else if (step) state_n = S_STEP;
      end
      S_RUN: begin
        if (exec) state_n = S_DRAIN;
      end
      default: state_n = state;
    endcase

    if (active && mem_ready)
      phase_n = {phase[NPHASE-2:0], phase[NPHASE-1]};

    // Halt wins over branch, step and drain; a stop request on the retire edge ends at this boundary.
    if (retire) begin
      retired_n = retired + CW'(1);
      phase_n   = NPHASE'(1);
      if (flag_we) flags_n = flags_in;
      if (halt_req) begin
        state_n = S_HALTED;
      end else begin
        pc_n = taken ? br_target : pc + AW'(1);
        if ((state != S_RUN) || exec) state_n = S_IDLE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase   <= NPHASE'(1);
      pc      <= RESET_PC;
      flags   <= 4'b0000;
      retired <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      phase   <= phase_n;
      pc      <= pc_n;
      flags   <= flags_n;
      retired <= retired_n;
      running <= (state_n == S_RUN) || (state_n == S_STEP) || (state_n == S_DRAIN);
      halted  <= (state_n == S_HALTED);
    end
  end

endmodule

// File: tb/tb_phase_run_controller.sv
`timescale 1ns/1ps
// Bench for phase_run_controller: instruction-level reference model compared every
// cycle, plus directed literal checks; a second AW=4 instance covers pc wrap and async reset.
module tb_phase_run_controller;

  localparam int unsigned NPH = 4;

  logic        clock = 1'b0;
  logic        reset, exec, step, mem_ready, halt_req, flag_we, br_en;
  logic [3:0]  flags_in;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [3:0]  phase;
  logic [15:0] pc;
  logic [3:0]  flags;
  logic        running, halted;
  logic [31:0] retired;

  logic        reset2, step2;
  logic [3:0]  s_phase, s_pc, s_flags;
  logic        s_running, s_halted;
  logic [31:0] s_retired;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  phase_run_controller dut (
    .clock(clock), .reset(reset), .exec(exec), .step(step), .mem_ready(mem_ready),
    .halt_req(halt_req), .flag_we(flag_we), .flags_in(flags_in), .br_en(br_en),
    .br_cond(br_cond), .br_target(br_target), .phase(phase), .pc(pc), .flags(flags),
    .running(running), .halted(halted), .retired(retired)
  );

  phase_run_controller #(.AW(4), .RESET_PC(4'hF)) dut_small (
    .clock(clock), .reset(reset2), .exec(1'b0), .step(step2), .mem_ready(mem_ready),
    .halt_req(halt_req), .flag_we(flag_we), .flags_in(flags_in), .br_en(br_en),
    .br_cond(br_cond), .br_target(br_target[3:0]), .phase(s_phase), .pc(s_pc),
    .flags(s_flags), .running(s_running), .halted(s_halted), .retired(s_retired)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one instruction = NPH ready cycles; effects land at the end.
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALT = 4;
  int          m_mode;
  int          m_idx;
  logic [15:0] m_pc;
  logic [3:0]  m_flags;
  logic [31:0] m_ret;

  function automatic bit cond_true(input logic [2:0] c, input logic [3:0] f);
    bit s = f[3], z = f[2], v = f[0];
    case (c)
      3'd0: return z;
      3'd1: return s != v;
      3'd2: return z || (s != v);
      3'd3: return !z;
      3'd4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_idx = 0; m_pc = 16'h0000; m_flags = 4'h0; m_ret = 0;
    end else if (m_mode == M_IDLE) begin
      if (exec)      m_mode = M_RUN;
      else if (step) m_mode = M_STEP;
    end else if (m_mode != M_HALT) begin
      if (mem_ready && m_idx == NPH - 1) begin
        bit tk;
        tk = br_en && cond_true(br_cond, m_flags);
        m_ret = m_ret + 1;
        m_idx = 0;
        if (flag_we) m_flags = flags_in;
        if (halt_req) m_mode = M_HALT;
        else begin
          m_pc = tk ? br_target : m_pc + 16'd1;
          if (m_mode != M_RUN || exec) m_mode = M_IDLE;
        end
      end else begin
        if (mem_ready) m_idx = m_idx + 1;
        if (m_mode == M_RUN && exec) m_mode = M_DRAIN;
      end
    end
  end

  bit cmp_en = 1'b1;
  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      chk("model_phase",   phase,   64'(1 << m_idx));
      chk("model_pc",      pc,      64'(m_pc));
      chk("model_flags",   flags,   64'(m_flags));
      chk("model_retired", retired, 64'(m_ret));
      chk("model_running", running, 64'(m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN));
      chk("model_halted",  halted,  64'(m_mode == M_HALT));
    end
  end

  task automatic clear_inputs();
    halt_req = 0; flag_we = 0; flags_in = 4'h0; br_en = 0; br_cond = 3'd0; br_target = 16'h0;
  endtask

  // Launch one stepped instruction with fixed decode inputs; returns at the idle cycle after retire.
  task automatic step_instr(input logic hr, input logic fwe, input logic [3:0] fin,
                            input logic ben, input logic [2:0] bc, input logic [15:0] bt);
    @(negedge clock);
    halt_req = hr; flag_we = fwe; flags_in = fin; br_en = ben; br_cond = bc; br_target = bt;
    step = 1;
    @(negedge clock);
    step = 0;
    repeat (NPH) @(negedge clock);
    clear_inputs();
  endtask

  initial begin
    reset = 1; reset2 = 1; exec = 0; step = 0; step2 = 0; mem_ready = 1;
    clear_inputs();
    repeat (2) @(negedge clock);
    chk("rst_phase", phase, 64'h1);
    chk("rst_pc", pc, 64'h0);
    chk("rst_running", running, 64'h0);
    chk("rst_small_pc", s_pc, 64'hF);
    reset = 0; reset2 = 0;

    // 1: stepped instruction, no stalls
    @(negedge clock); step = 1;
    @(negedge clock); step = 0;
    chk("t1_phase0", phase, 64'h1);
    @(negedge clock); chk("t1_phase1", phase, 64'h2);
    @(negedge clock); chk("t1_phase2", phase, 64'h4);
    @(negedge clock); chk("t1_phase3", phase, 64'h8);
    @(negedge clock);
    chk("t1_phase_back", phase, 64'h1);
    chk("t1_pc", pc, 64'h1);
    chk("t1_retired", retired, 64'h1);
    chk("t1_idle", running, 64'h0);

    // 2: RUN with three wait states in phase 2
    @(negedge clock); exec = 1;
    @(negedge clock); exec = 0; chk("t2_c1", phase, 64'h1);
    @(negedge clock); chk("t2_c2", phase, 64'h2); mem_ready = 0;
    @(negedge clock); chk("t2_c3", phase, 64'h2);
    @(negedge clock); chk("t2_c4", phase, 64'h2);
    @(negedge clock); chk("t2_c5", phase, 64'h2); mem_ready = 1;
    @(negedge clock); chk("t2_c6", phase, 64'h4);
    @(negedge clock); chk("t2_c7", phase, 64'h8);
    @(negedge clock);
    chk("t2_retired", retired, 64'h2);
    chk("t2_still_run", running, 64'h1);
    exec = 1;
    @(negedge clock); exec = 0;
    for (int i = 0; i < 20 && running; i++) @(negedge clock);
    chk("t2_drained", running, 64'h0);
    chk("t2_pc", pc, 64'h3);

    // 3: conditional branches on Z
    step_instr(0, 1, 4'b0100, 0, 3'd0, 16'h0);
    chk("t3_flags", flags, 64'h4);
    step_instr(0, 0, 4'h0, 1, 3'b000, 16'h0040);
    chk("t3_be_taken", pc, 64'h40);
    step_instr(0, 0, 4'h0, 1, 3'b011, 16'h0040);
    chk("t3_bne_not", pc, 64'h41);
    step_instr(0, 0, 4'h0, 1, 3'b101, 16'h0040);
    chk("t3_never", pc, 64'h42);

    // 4: branch uses flags from before the same-retire write
    step_instr(0, 1, 4'b1000, 1, 3'b001, 16'h0080);
    chk("t4_blt_old", pc, 64'h43);
    chk("t4_flags", flags, 64'h8);
    step_instr(0, 0, 4'h0, 1, 3'b001, 16'h0080);
    chk("t4_blt_new", pc, 64'h80);

    // 5: stop request mid-instruction, then HALT
    @(negedge clock); exec = 1;
    @(negedge clock); exec = 0;
    @(negedge clock); exec = 1; chk("t5_in_p2", phase, 64'h2);
    @(negedge clock); exec = 0;
    @(negedge clock);
    @(negedge clock);
    chk("t5_idle", running, 64'h0);
    chk("t5_phase", phase, 64'h1);
    chk("t5_pc", pc, 64'h81);
    step_instr(1, 0, 4'h0, 1, 3'b100, 16'h0010);
    chk("t5_halted", halted, 64'h1);
    chk("t5_halt_pc", pc, 64'h81);
    chk("t5_halt_ret", retired, 64'd11);
    @(negedge clock); exec = 1;
    @(negedge clock); exec = 0; step = 1;
    @(negedge clock); step = 0;
    repeat (3) @(negedge clock);
    chk("t5_frozen_halt", halted, 64'h1);
    chk("t5_frozen_pc", pc, 64'h81);
    chk("t5_frozen_phase", phase, 64'h1);
    reset = 1;
    @(negedge clock); reset = 0;
    chk("t5_rst_halted", halted, 64'h0);
    chk("t5_rst_ret", retired, 64'h0);

    // 6: AW=4 pc wrap, then async reset mid-instruction
    @(negedge clock); step2 = 1;
    @(negedge clock); step2 = 0;
    repeat (NPH) @(negedge clock);
    chk("t6_wrap_pc", s_pc, 64'h0);
    chk("t6_retired", s_retired, 64'h1);
    @(negedge clock); step2 = 1;
    @(negedge clock); step2 = 0;
    @(negedge clock);
    @(negedge clock);
    chk("t6_in_p4", s_phase, 64'h4);
    #2 reset2 = 1;
    #1;
    chk("t6_rst_phase", s_phase, 64'h1);
    chk("t6_rst_pc", s_pc, 64'hF);
    chk("t6_rst_flags", s_flags, 64'h0);
    chk("t6_rst_running", s_running, 64'h0);
    chk("t6_rst_halted", s_halted, 64'h0);
    chk("t6_rst_retired", s_retired, 64'h0);
    @(negedge clock); reset2 = 0;
    @(negedge clock);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
